fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-003 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Rst  input  1  reset; synchronous, active-high.
REQ-005 Stall  input  1  decode stage not accepting; head entry held.
REQ-006 Flush  input  1  redirect request (taken branch or jump).
REQ-007 TargetPC  input  32  redirect address, sampled when Flush=1.
REQ-008 MemAddr  output  32  instruction-memory read address; equals FetchPC, combinational.
REQ-009 MemData  input  32  instruction word; MemAddr to MemData is combinational, same cycle.
REQ-010 Instr  output  32  head instruction; 32'h0000_0000 (NOP) when Valid=0.
REQ-011 PCnext  output  32  head instruction address + 4; 32'h0 when Valid=0.
REQ-012 Valid  output  1  head entry present.
REQ-013 Count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-014 Internal FetchPC register SHALL drive MemAddr; the queue SHALL store {MemData, FetchPC+4} pairs.
REQ-015 Push: when Flush=0 and space exists, the current pair SHALL be written at the tail and FetchPC SHALL advance by 4 at the same edge.
REQ-016 Space SHALL exist when Count<DEPTH, or when Count=DEPTH and a pop occurs in the same cycle.
REQ-017 Pop: when Valid=1, Stall=0 and Flush=0, the head SHALL be removed at the edge.
REQ-018 Instr, PCnext and Valid SHALL be driven combinationally from the head entry, so a pushed entry becomes visible one cycle after its push edge.
REQ-019 Simultaneous push and pop SHALL leave Count unchanged; push only increments Count, pop only decrements it.
REQ-020 Full (Count=DEPTH) with no pop: no push, FetchPC held, MemAddr stable.
REQ-021 Empty (Count=0): Valid=0, Instr=0, PCnext=0; a Stall has no effect.
REQ-022 Head and tail pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-023 Flush SHALL dominate Stall, push and pop. At the edge: Count=0, pointers=0, FetchPC=TargetPC.
REQ-024 After a Flush, Valid SHALL be 0 in the following cycle; the first instruction from TargetPC SHALL appear one cycle later.
REQ-025 TargetPC SHALL be used verbatim; the block does no alignment checking.
REQ-026 Adder width: FetchPC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).

Reset
REQ-027 While Rst=1 at an edge: FetchPC=RESET_PC, Count=0, pointers=0. Rst SHALL take priority over Flush.
REQ-028 Outputs after reset: Valid=0, Instr=0, PCnext=0, MemAddr=RESET_PC.
REQ-029 Rst asserted mid-operation SHALL discard all queued entries at that edge; there is no partial retention.
REQ-030 The first instruction (address RESET_PC) SHALL be visible one cycle after the first edge with Rst=0.

Structure
REQ-031 The shared pipeline package SHALL hold: DEPTH default, NOP constant 32'h0, PC increment constant 4, and the 64-bit entry layout {instr[63:32], pcnext[31:0]}.
REQ-032 The storage array and its pointers SHALL be one sub-module, fetch_queue_mem (write port at tail, asynchronous read at head).
REQ-033 FetchPC, the occupancy counter and the push/pop/flush control SHALL live in fetch_queue.

Verification
REQ-034 Reset, then Stall=0 for 6 cycles; memory returns addr>>2 -> Instr sequence 0,1,2,3,... with PCnext 4,8,12,..., Valid=1 from cycle 2, Count stays 1.
REQ-035 Stall=1 for 8 cycles after reset -> Count rises to 4 and saturates, MemAddr frozen at 32'h10, head Instr stays 0; release Stall -> entries 0..4 emerge in order.
REQ-036 Flush with TargetPC=32'h40 while Count=3 and Stall=1 -> next cycle Valid=0, Count=0; following cycle Instr=MEM[0x40], PCnext=32'h44.
REQ-037 Count=4 with Stall=0 for 20 cycles -> pointer wrap occurs, Count remains 4, no address skipped or repeated.
REQ-038 Rst asserted with Count=2, Flush=1 and TargetPC=32'h80 in the same cycle -> FetchPC=RESET_PC, Count=0, Valid=0.
REQ-039 FetchPC forced to 32'hFFFF_FFFC via Flush -> entry carries PCnext=32'h0, and the next MemAddr is 32'h0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared fetch pipeline definitions: queue depth default, NOP word,
// PC increment and the 64-bit queue entry layout.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH = 4;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  // Entry layout: instr in [63:32], address of the following instruction in [31:0]
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcnext;
  } fq_entry_t;

  function automatic fq_entry_t make_entry(input logic [31:0] instr, input logic [31:0] pc);
    fq_entry_t e;
    e.instr  = instr;
    e.pcnext = pc + PC_INC;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Circular entry storage for the fetch queue: write port at the tail,
// asynchronous read of the head, pointers cleared by reset or flush.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      push,
  input  logic      pop,
  input  fq_entry_t wr_entry,
  output fq_entry_t rd_entry
);

  localparam int unsigned PW = $clog2(DEPTH);

  fq_entry_t       mem_r [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;

  // Entry storage, written at the tail on every push
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[tail_r] <= wr_entry;
    end
  end

  // Head/tail pointers; DEPTH is a power of two so natural overflow wraps them
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head_r <= PW'(0);
      tail_r <= PW'(0);
    end else begin
      if (push) begin
        tail_r <= tail_r + PW'(1);
      end
      if (pop) begin
        head_r <= head_r + PW'(1);
      end
    end
  end

  assign rd_entry = mem_r[head_r];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns FetchPC, the occupancy counter and the
// push/pop/flush control around the fetch_queue_mem storage.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Stall,
  input  logic                     Flush,
  input  logic [31:0]              TargetPC,
  output logic [31:0]              MemAddr,
  input  logic [31:0]              MemData,
  output logic [31:0]              Instr,
  output logic [31:0]              PCnext,
  output logic                     Valid,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   fetch_pc_nx_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nx_s;
  logic          valid_s;
  logic          push_s;
  logic          pop_s;
  fq_entry_t     wr_entry_s;
  fq_entry_t     head_entry_s;

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk      (Clk),
    .rst      (Rst),
    .clr      (Flush),
    .push     (push_s),
    .pop      (pop_s),
    .wr_entry (wr_entry_s),
    .rd_entry (head_entry_s)
  );

  // Push/pop decisions; a full queue still accepts when the head leaves this cycle
  always_comb begin
    valid_s    = (count_r != ZERO_CNT);
    pop_s      = valid_s && !Stall && !Flush && !Rst;
    push_s     = !Flush && !Rst && ((count_r < FULL_CNT) || pop_s);
    wr_entry_s = make_entry(MemData, fetch_pc_r);
  end

  // Next occupancy and next fetch address
  always_comb begin
    count_nx_s    = count_r;
    fetch_pc_nx_s = fetch_pc_r;
    if (Flush) begin
      count_nx_s    = ZERO_CNT;
      fetch_pc_nx_s = TargetPC;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nx_s = count_r + ONE_CNT;
        2'b01:   count_nx_s = count_r - ONE_CNT;
        default: count_nx_s = count_r;
      endcase
      if (push_s) begin
        fetch_pc_nx_s = fetch_pc_r + PC_INC;
      end else begin
        fetch_pc_nx_s = fetch_pc_r;
      end
    end
  end

  // State registers; reset outranks flush
  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_pc_r <= RESET_PC;
      count_r    <= ZERO_CNT;
    end else begin
      fetch_pc_r <= fetch_pc_nx_s;
      count_r    <= count_nx_s;
    end
  end

  // Head presentation, forced to NOP/zero when the queue is empty
  always_comb begin
    MemAddr = fetch_pc_r;
    Count   = count_r;
    Valid   = valid_s;
    if (valid_s) begin
      Instr  = head_entry_s.instr;
      PCnext = head_entry_s.pcnext;
    end else begin
      Instr  = NOP;
      PCnext = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand sequences
// for flush/reset/wrap corners, and random traffic against a queue model.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        Flush;
  logic [31:0] TargetPC;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic [31:0] Instr;
  logic [31:0] PCnext;
  logic        Valid;
  logic [2:0]  Count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Stall    (Stall),
    .Flush    (Flush),
    .TargetPC (TargetPC),
    .MemAddr  (MemAddr),
    .MemData  (MemData),
    .Instr    (Instr),
    .PCnext   (PCnext),
    .Valid    (Valid),
    .Count    (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int mem_mode = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a, input int mode);
    if (mode == 0) return a >> 2;
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  always_comb MemData = mem_fn(MemAddr, mem_mode);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of fetched words plus the fetch address
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcn;
  } ment_t;
  ment_t       mq[$];
  logic [31:0] m_pc;

  task automatic step(input logic rst, input logic stall, input logic flush, input logic [31:0] tgt);
    ment_t e;
    bit pop;
    bit space;
    logic [31:0] d;
    Rst = rst; Stall = stall; Flush = flush; TargetPC = tgt;
    d = mem_fn(m_pc, mem_mode);
    @(posedge Clk);
    if (rst) begin
      mq.delete();
      m_pc = RESET_PC;
    end else if (flush) begin
      mq.delete();
      m_pc = tgt;
    end else begin
      pop   = (mq.size() > 0) && !stall;
      space = (mq.size() < DEPTH) || pop;
      if (pop) mq.delete(0);
      if (space) begin
        e.instr = d;
        e.pcn   = m_pc + 32'd4;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] ei;
    logic [31:0] ep;
    ei = (mq.size() > 0) ? mq[0].instr : 32'h0;
    ep = (mq.size() > 0) ? mq[0].pcn   : 32'h0;
    chk({tag, " valid"},   32'(Valid),   32'(mq.size() > 0));
    chk({tag, " instr"},   Instr,        ei);
    chk({tag, " pcnext"},  PCnext,       ep);
    chk({tag, " count"},   32'(Count),   32'(mq.size()));
    chk({tag, " memaddr"}, MemAddr,      m_pc);
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcn;
    logic [2:0]  cnt;
    logic [31:0] addr;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t v(input logic rst, input logic stall, input logic valid,
                             input logic [31:0] instr, input logic [31:0] pcn,
                             input logic [2:0] cnt, input logic [31:0] addr);
    vec_t r;
    r.rst = rst; r.stall = stall; r.valid = valid;
    r.instr = instr; r.pcn = pcn; r.cnt = cnt; r.addr = addr;
    return r;
  endfunction

  initial begin
    Rst = 1'b1; Stall = 1'b0; Flush = 1'b0; TargetPC = 32'h0;
    m_pc = RESET_PC;

    // Streaming after reset, then a stalled fill to saturation and drain
    vt.push_back(v(1'b1, 1'b0, 1'b0, 32'd0, 32'd0,  3'd0, 32'd0));
    vt.push_back(v(1'b0, 1'b0, 1'b1, 32'd0, 32'd4,  3'd1, 32'd4));
    vt.push_back(v(1'b0, 1'b0, 1'b1, 32'd1, 32'd8,  3'd1, 32'd8));
    vt.push_back(v(1'b0, 1'b0, 1'b1, 32'd2, 32'd12, 3'd1, 32'd12));
    vt.push_back(v(1'b0, 1'b0, 1'b1, 32'd3, 32'd16, 3'd1, 32'd16));
    vt.push_back(v(1'b0, 1'b0, 1'b1, 32'd4, 32'd20, 3'd1, 32'd20));
    vt.push_back(v(1'b0, 1'b0, 1'b1, 32'd5, 32'd24, 3'd1, 32'd24));
    vt.push_back(v(1'b1, 1'b1, 1'b0, 32'd0, 32'd0,  3'd0, 32'd0));
    vt.push_back(v(1'b0, 1'b1, 1'b1, 32'd0, 32'd4,  3'd1, 32'd4));
    vt.push_back(v(1'b0, 1'b1, 1'b1, 32'd0, 32'd4,  3'd2, 32'd8));
    vt.push_back(v(1'b0, 1'b1, 1'b1, 32'd0, 32'd4,  3'd3, 32'd12));
    for (int i = 0; i < 5; i++)
      vt.push_back(v(1'b0, 1'b1, 1'b1, 32'd0, 32'd4, 3'd4, 32'd16));
    vt.push_back(v(1'b0, 1'b0, 1'b1, 32'd1, 32'd8,  3'd4, 32'd20));
    vt.push_back(v(1'b0, 1'b0, 1'b1, 32'd2, 32'd12, 3'd4, 32'd24));
    vt.push_back(v(1'b0, 1'b0, 1'b1, 32'd3, 32'd16, 3'd4, 32'd28));
    vt.push_back(v(1'b0, 1'b0, 1'b1, 32'd4, 32'd20, 3'd4, 32'd32));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rst, vt[i].stall, 1'b0, 32'h0);
      chk($sformatf("vec%0d valid", i),   32'(Valid),   32'(vt[i].valid));
      chk($sformatf("vec%0d instr", i),   Instr,        vt[i].instr);
      chk($sformatf("vec%0d pcnext", i),  PCnext,       vt[i].pcn);
      chk($sformatf("vec%0d count", i),   32'(Count),   32'(vt[i].cnt));
      chk($sformatf("vec%0d memaddr", i), MemAddr,      vt[i].addr);
    end

    // Flush while stalled with three entries queued
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("flush pre count", 32'(Count), 32'd3);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    chk("flush valid", 32'(Valid), 32'd0);
    chk("flush count", 32'(Count), 32'd0);
    chk("flush instr", Instr, 32'h0);
    chk("flush memaddr", MemAddr, 32'h40);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("flush first instr", Instr, 32'h10);
    chk("flush first pcnext", PCnext, 32'h44);
    chk("flush first valid", 32'(Valid), 32'd1);

    // Full queue streaming long enough to wrap the pointers several times
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("wrap%0d count", i), 32'(Count), 32'd4);
      chk($sformatf("wrap%0d instr", i), Instr, 32'(i + 1));
      chk($sformatf("wrap%0d pcnext", i), PCnext, 32'((i + 2) * 4));
    end

    // Reset coinciding with a flush wins
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rstflush pre count", 32'(Count), 32'd2);
    step(1'b1, 1'b1, 1'b1, 32'h80);
    chk("rstflush memaddr", MemAddr, RESET_PC);
    chk("rstflush count", 32'(Count), 32'd0);
    chk("rstflush valid", 32'(Valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rstflush first pcnext", PCnext, RESET_PC + 32'd4);

    // FetchPC at the top of the address space wraps to zero
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap32 memaddr", MemAddr, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap32 pcnext", PCnext, 32'h0);
    chk("wrap32 instr", Instr, 32'h3FFF_FFFF);
    chk("wrap32 memaddr next", MemAddr, 32'h0);

    // Random traffic against the queue model
    mem_mode = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_model("rnd reset");
    for (int i = 0; i < 400; i++) begin
      logic        r_rst;
      logic        r_flush;
      logic        r_stall;
      logic [31:0] r_tgt;
      r_rst   = ($urandom % 64) == 0;
      r_flush = ($urandom % 12) == 0;
      r_stall = ($urandom % 2) == 0;
      r_tgt   = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : 32'($urandom);
      step(r_rst, r_stall, r_flush, r_tgt);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
